// File: rtl/fifo_chk_pkg.sv
// Shared constants and state encoding for the FIFO protocol checker.
// Error-vector bit positions are fixed here so monitors and benches agree.
package fifo_chk_pkg;

    localparam int ERR_W     = 6;
    localparam int ERR_RST   = 0;
    localparam int ERR_FULL  = 1;
    localparam int ERR_EMPTY = 2;
    localparam int ERR_OVF   = 3;
    localparam int ERR_UDF   = 4;
    localparam int ERR_DATA  = 5;

    typedef enum logic [1:0] {
        RESET    = 2'd0,
        INIT_CHK = 2'd1,
        RUN      = 2'd2,
        HALT     = 2'd3
    } chk_state_e;

endpackage

// File: rtl/fifo_chk_model.sv
// Shadow FIFO used by the protocol checker: storage, wrapping pointers,
// occupancy and the registered expected read word.
module fifo_chk_model #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr_req,
    input  logic             rd_req,
    input  logic [WIDTH-1:0] data_in,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] exp_data,
    output logic             exp_valid
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             wr;
    logic             rd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Bounds keep the shadow sane even when the DUT flags lie.
    assign wr = en & wr_req & (count != CW'(DEPTH));
    assign rd = en & rd_req & (count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            exp_valid <= 1'b0;
        end else begin
            exp_valid <= rd;
            if (wr) wptr <= ptr_inc(wptr);
            if (rd) rptr <= ptr_inc(rptr);
            case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Read takes the pre-write head, so a same-cycle write never bypasses.
    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= data_in;
        if (rd) exp_data  <= mem[rptr];
    end

endmodule

// File: rtl/fifo_protocol_checker.sv
// Protocol monitor for a single-clock FIFO: flag, overflow/underflow and data checks.
// Define FIFO_CHK_ASSERT_EN to add one concurrent assertion per error bit.
module fifo_protocol_checker
    import fifo_chk_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 8,
    parameter int STOP_ON_ERR = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         w_en,
    input  logic                         r_en,
    input  logic [WIDTH-1:0]             data_in,
    input  logic [WIDTH-1:0]             data_out,
    input  logic                         full,
    input  logic                         empty,
    input  logic                         err_clr,
    output logic [ERR_W-1:0]             err_vec,
    output logic                         err_pulse,
    output logic [CNT_W-1:0]             err_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   exp_count,
    output logic [1:0]                   chk_state
);

    localparam int CW = $clog2(DEPTH + 1);

    chk_state_e       state;
    chk_state_e       state_nxt;
    logic [WIDTH-1:0] exp_data;
    logic             exp_valid;
    logic [ERR_W-1:0] chk;
    logic [ERR_W-1:0] pend;
    logic [ERR_W-1:0] errs;
    logic             any_err;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    fifo_chk_model #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_model (
        .clk       (clk),
        .rst       (rst),
        .en        (state == RUN),
        .wr_req    (w_en & ~full),
        .rd_req    (r_en & ~empty),
        .data_in   (data_in),
        .count     (exp_count),
        .exp_data  (exp_data),
        .exp_valid (exp_valid)
    );

    always_comb begin
        chk = '0;
        if (state == INIT_CHK) begin
            chk[ERR_RST] = ~(empty & ~full & ~w_en & ~r_en);
        end else if (state == RUN) begin
            chk[ERR_FULL]  = full != (exp_count == CW'(DEPTH));
            chk[ERR_EMPTY] = empty != (exp_count == '0);
            chk[ERR_OVF]   = w_en & full;
            chk[ERR_UDF]   = r_en & empty;
            chk[ERR_DATA]  = exp_valid & (data_out != exp_data);
        end
    end

    // Errors masked by a same-cycle clear are carried one cycle in pend.
    assign errs    = chk | pend;
    assign any_err = |errs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RESET;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RESET:    state_nxt = INIT_CHK;
            INIT_CHK: state_nxt = RUN;
            RUN:      if ((STOP_ON_ERR != 0) && any_err && !err_clr) state_nxt = HALT;
            HALT:     if (err_clr) state_nxt = RUN;
            default:  state_nxt = RESET;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_vec   <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            pend      <= '0;
        end else if (err_clr) begin
            err_vec   <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            pend      <= errs;
        end else begin
            pend <= '0;
            if (state == HALT) begin
                err_pulse <= 1'b0;
            end else begin
                err_vec   <= err_vec | errs;
                err_pulse <= any_err;
                if (any_err) err_cnt <= sat_inc(err_cnt);
            end
        end
    end

    assign chk_state = state;

`ifdef FIFO_CHK_ASSERT_EN
    a_rst:   assert property (@(posedge clk) disable iff (rst) !chk[ERR_RST])
        else $error("fifo_chk RST check violated at %0t", $time);
    a_full:  assert property (@(posedge clk) disable iff (rst) !chk[ERR_FULL])
        else $error("fifo_chk FULL check violated at %0t", $time);
    a_empty: assert property (@(posedge clk) disable iff (rst) !chk[ERR_EMPTY])
        else $error("fifo_chk EMPTY check violated at %0t", $time);
    a_ovf:   assert property (@(posedge clk) disable iff (rst) !chk[ERR_OVF])
        else $error("fifo_chk OVF check violated at %0t", $time);
    a_udf:   assert property (@(posedge clk) disable iff (rst) !chk[ERR_UDF])
        else $error("fifo_chk UDF check violated at %0t", $time);
    a_data:  assert property (@(posedge clk) disable iff (rst) !chk[ERR_DATA])
        else $error("fifo_chk DATA check violated at %0t", $time);
`endif

endmodule

// File: tb/tb_fifo_protocol_checker.sv
// Bench: an emulated FIFO drives the checker; a queue-based model predicts its outputs.
// A second instance with STOP_ON_ERR=1 is exercised with hand-computed expectations.
module tb_fifo_protocol_checker;
    import fifo_chk_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic w_en = 1'b0, r_en = 1'b0, err_clr = 1'b0;
    logic full = 1'b0, empty = 1'b1;
    logic [15:0] data_in = '0, data_out = '0;
    logic [5:0] err_vec;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic [3:0] exp_count;
    logic [1:0] chk_state;

    logic h_rst = 1'b1;
    logic h_w_en = 1'b0, h_r_en = 1'b0, h_clr = 1'b0;
    logic h_full = 1'b0, h_empty = 1'b0;
    logic [15:0] h_din = '0, h_dout = '0;
    logic [5:0] h_err_vec;
    logic       h_err_pulse;
    logic [7:0] h_err_cnt;
    logic [3:0] h_exp_count;
    logic [1:0] h_chk_state;

    int checks = 0;
    int failures = 0;

    // Emulated DUT FIFO and fault injection knobs.
    logic [15:0] fq[$];
    bit inj_data = 0, inj_full = 0, inj_empty = 0, clr_req = 0;

    // Behavioural model of the checker.
    logic [15:0] mq[$];
    chk_state_e  m_state;
    logic [5:0]  m_vec, m_pend;
    logic        m_pulse, m_expv;
    logic [15:0] m_expd;
    int          m_cnt;

    fifo_protocol_checker #(.WIDTH(16), .DEPTH(DEPTH), .CNT_W(CNT_W), .STOP_ON_ERR(0)) u_dut (
        .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in),
        .data_out(data_out), .full(full), .empty(empty), .err_clr(err_clr),
        .err_vec(err_vec), .err_pulse(err_pulse), .err_cnt(err_cnt),
        .exp_count(exp_count), .chk_state(chk_state)
    );

    fifo_protocol_checker #(.WIDTH(16), .DEPTH(DEPTH), .CNT_W(CNT_W), .STOP_ON_ERR(1)) u_halt (
        .clk(clk), .rst(h_rst), .w_en(h_w_en), .r_en(h_r_en), .data_in(h_din),
        .data_out(h_dout), .full(h_full), .empty(h_empty), .err_clr(h_clr),
        .err_vec(h_err_vec), .err_pulse(h_err_pulse), .err_cnt(h_err_cnt),
        .exp_count(h_exp_count), .chk_state(h_chk_state)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_state = RESET;
        m_vec = '0; m_pend = '0; m_pulse = 1'b0; m_expv = 1'b0; m_expd = '0; m_cnt = 0;
    endtask

    // One clock edge of the checker's rules, applied to the sampled inputs.
    task automatic model_step();
        logic [5:0] e;
        bit do_r, do_w;
        int n;
        if (rst) begin
            model_reset();
            return;
        end
        n = mq.size();
        e = '0;
        if (m_state == INIT_CHK) begin
            e[ERR_RST] = !(empty && !full && !w_en && !r_en);
        end else if (m_state == RUN) begin
            e[ERR_FULL]  = (full == 1'b1) != (n == DEPTH);
            e[ERR_EMPTY] = (empty == 1'b1) != (n == 0);
            e[ERR_OVF]   = w_en && full;
            e[ERR_UDF]   = r_en && empty;
            e[ERR_DATA]  = m_expv && (data_out != m_expd);
        end
        e = e | m_pend;
        do_r = (m_state == RUN) && r_en && !empty && (n > 0);
        do_w = (m_state == RUN) && w_en && !full && (n < DEPTH);
        m_expv = do_r;
        if (do_r) m_expd = mq.pop_front();
        if (do_w) mq.push_back(data_in);
        if (err_clr) begin
            m_vec = '0; m_cnt = 0; m_pulse = 1'b0; m_pend = e;
        end else begin
            m_pend = '0;
            m_vec = m_vec | e;
            m_pulse = |e;
            if ((|e) && m_cnt < CMAX) m_cnt++;
        end
        if (m_state == RESET) m_state = INIT_CHK;
        else if (m_state == INIT_CHK) m_state = RUN;
    endtask

    // Present inputs, clock once, then let the emulated FIFO respond.
    task automatic step(input logic we, input logic re, input logic [15:0] din);
        logic [15:0] rv;
        w_en = we; r_en = re; data_in = din; err_clr = clr_req;
        full  = (fq.size() == DEPTH) ^ inj_full;
        empty = (fq.size() == 0) ^ inj_empty;
        @(posedge clk);
        model_step();
        #1;
        if (!rst) begin
            if (r_en && !empty && fq.size() > 0) begin
                rv = fq.pop_front();
                data_out = inj_data ? 16'hDEAD : rv;
            end
            if (w_en && !full && fq.size() < DEPTH) fq.push_back(data_in);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        fq.delete();
        model_reset();
        repeat (n) step(0, 0, 16'h0);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            check("cmp_err_vec",   err_vec,   m_vec);
            check("cmp_err_pulse", err_pulse, m_pulse);
            check("cmp_err_cnt",   err_cnt,   m_cnt);
            check("cmp_exp_count", exp_count, mq.size());
            check("cmp_chk_state", chk_state, m_state);
        end
    end

    initial begin
        // Reset and release
        do_reset(3);
        check("rst_state", chk_state, 2'd0);
        check("rst_vec", err_vec, 6'd0);
        step(0, 0, 16'h0);
        step(0, 0, 16'h0);
        check("init_to_run", chk_state, 2'd2);
        check("init_vec", err_vec, 6'd0);
        check("init_cnt", err_cnt, 8'd0);

        // Fill and drain with a well-behaved FIFO
        for (int i = 1; i <= 8; i++) step(1, 0, 16'(i));
        check("fill_count", exp_count, 4'd8);
        for (int i = 0; i < 8; i++) step(0, 1, 16'h0);
        step(0, 0, 16'h0);
        check("drain_vec", err_vec, 6'd0);
        check("drain_count", exp_count, 4'd0);

        // Corrupted third read
        for (int i = 1; i <= 5; i++) step(1, 0, 16'(i));
        step(0, 1, 16'h0);
        step(0, 1, 16'h0);
        inj_data = 1;
        step(0, 1, 16'h0);
        inj_data = 0;
        step(0, 1, 16'h0);
        check("data_vec", err_vec, 6'd1 << ERR_DATA);
        check("data_pulse", err_pulse, 1'b1);
        check("data_cnt", err_cnt, 8'd1);
        step(0, 1, 16'h0);
        check("data_pulse_end", err_pulse, 1'b0);
        step(0, 0, 16'h0);
        check("data_cnt_hold", err_cnt, 8'd1);
        clr_req = 1;
        step(0, 0, 16'h0);
        clr_req = 0;
        check("clr_vec", err_vec, 6'd0);
        check("clr_cnt", err_cnt, 8'd0);

        // Overflow attempts against a full FIFO
        for (int i = 0; i < 8; i++) step(1, 0, 16'h0010 + 16'(i));
        repeat (3) step(1, 0, 16'h0099);
        check("ovf_vec", err_vec, 6'd1 << ERR_OVF);
        check("ovf_cnt", err_cnt, 8'd3);
        check("ovf_count", exp_count, 4'd8);

        // Concurrent read/write at occupancy 4 across a pointer wrap
        repeat (4) step(0, 1, 16'h0);
        for (int i = 0; i < 20; i++) step(1, 1, 16'($urandom));
        step(0, 0, 16'h0);
        check("rw_count", exp_count, 4'd4);
        check("rw_cnt", err_cnt, 8'd3);
        check("rw_vec", err_vec, 6'd1 << ERR_OVF);
        clr_req = 1;
        step(0, 0, 16'h0);
        clr_req = 0;

        // Random traffic with occasional faults and clears
        for (int i = 0; i < 400; i++) begin
            inj_data  = ($urandom_range(0, 24) == 0);
            inj_full  = ($urandom_range(0, 39) == 0);
            inj_empty = ($urandom_range(0, 39) == 0);
            clr_req   = ($urandom_range(0, 29) == 0);
            step(1'($urandom), 1'($urandom), 16'($urandom));
        end
        inj_data = 0; inj_full = 0; inj_empty = 0; clr_req = 0;

        // Reset during traffic
        step(1, 1, 16'h1234);
        do_reset(1);
        check("midrst_count", exp_count, 4'd0);
        check("midrst_vec", err_vec, 6'd0);
        check("midrst_state", chk_state, 2'd0);
        step(0, 0, 16'h0);
        step(0, 0, 16'h0);

        // Underflow until the counter saturates
        repeat (300) step(0, 1, 16'h0);
        check("sat_cnt", err_cnt, 8'd255);
        check("sat_vec", err_vec, 6'd1 << ERR_UDF);

        // Clear wins over a same-cycle error, which lands one cycle later
        clr_req = 1;
        step(0, 1, 16'h0);
        clr_req = 0;
        check("clrpri_vec", err_vec, 6'd0);
        check("clrpri_cnt", err_cnt, 8'd0);
        step(0, 0, 16'h0);
        check("pend_vec", err_vec, 6'd1 << ERR_UDF);
        check("pend_cnt", err_cnt, 8'd1);
        check("pend_pulse", err_pulse, 1'b1);

        // STOP_ON_ERR instance: empty wrongly low out of reset
        h_rst = 1'b0;
        check("h_reset_state", h_chk_state, 2'd0);
        step(0, 0, 16'h0);
        check("h_init_state", h_chk_state, 2'd1);
        step(0, 0, 16'h0);
        check("h_run_state", h_chk_state, 2'd2);
        check("h_rst_vec", h_err_vec, 6'd1 << ERR_RST);
        check("h_rst_cnt", h_err_cnt, 8'd1);
        step(0, 0, 16'h0);
        check("h_halt_state", h_chk_state, 2'd3);
        check("h_halt_vec", h_err_vec, (6'd1 << ERR_RST) | (6'd1 << ERR_EMPTY));
        check("h_halt_cnt", h_err_cnt, 8'd2);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 16'h0);
            check("h_hold_state", h_chk_state, 2'd3);
            check("h_hold_cnt", h_err_cnt, 8'd2);
            check("h_hold_pulse", h_err_pulse, 1'b0);
        end
        h_empty = 1'b1;
        h_clr = 1'b1;
        step(0, 0, 16'h0);
        h_clr = 1'b0;
        check("h_resume_state", h_chk_state, 2'd2);
        check("h_resume_vec", h_err_vec, 6'd0);
        check("h_resume_cnt", h_err_cnt, 8'd0);
        step(0, 0, 16'h0);
        check("h_clean_state", h_chk_state, 2'd2);
        check("h_clean_vec", h_err_vec, 6'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
